// File: rtl/chan_sel_mux.sv
// Registered N-channel mux with valid/ready on every input and on the output.
// Selects a channel by explicit code (mode 0) or round-robin (mode 1).
module chan_sel_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int SELW  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             can_load;
  logic [SELW-1:0]  rr_ptr;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] grant_word;
  logic [SELW-1:0]  rr_next;

  // A slot opens when the register is empty or is being drained this cycle.
  assign can_load = !out_valid || out_ready;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin : arbiter
    logic [2*N-1:0] rot;
    int             c;
    grant_any = 1'b0;
    grant_idx = '0;
    rot       = '0;
    c         = 0;
    if (can_load) begin
      if (!mode) begin
        // Codes >= N never match any k, so they grant nothing.
        for (int k = 0; k < N; k++) begin
          if (sel == SELW'(k) && in_valid[k]) begin
            grant_any = 1'b1;
            grant_idx = SELW'(k);
          end
        end
      end else begin
        // Rotate so bit 0 is the channel at rr_ptr; lowest set bit wins.
        rot = {in_valid, in_valid} >> rr_ptr;
        for (int j = N - 1; j >= 0; j--) begin
          if (rot[j]) begin
            grant_any = 1'b1;
            c         = int'(rr_ptr) + j;
          end
        end
        if (c >= N) c = c - N;
        grant_idx = SELW'(c);
      end
    end
  end

  always_comb begin : grant_decode
    grant      = '0;
    grant_word = '0;
    for (int k = 0; k < N; k++) begin
      grant[k] = grant_any && (grant_idx == SELW'(k));
      if (grant[k]) grant_word = grant_word | in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin : rr_wrap
    int nx;
    nx = int'(grant_idx) + 1;
    if (nx >= N) nx = 0;
    rr_next = SELW'(nx);
  end

  // The output register is cleared asynchronously, so gate in_ready with the
  // reset as well: no source may see an accept while the block is held in reset.
  assign in_ready = grant & {N{reset_n}};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (grant_any) begin
        out_data  <= grant_word;
        out_chan  <= grant_idx;
        out_valid <= 1'b1;
        if (mode) rr_ptr <= rr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_sel_mux.sv
// Directed bench for chan_sel_mux with a reference model and an output scoreboard.
// A second instance (N=12, SELW=5) covers out-of-range select codes.
module tb_chan_sel_mux;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int SW = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] c;
  } item_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SW-1:0]    sel;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_chan;
  logic             out_valid;
  logic             out_ready;

  logic [11:0]      in_ready2;
  logic [4:0]       sel2;
  logic [W-1:0]     out_data2;
  logic [4:0]       out_chan2;
  logic             out_valid2;

  item_t            sbq[$];
  int               total = 0;
  int               bad   = 0;
  logic             m_valid;
  logic [SW-1:0]    m_ptr;
  logic [7:0]       tag;

  always #5 clk = ~clk;

  chan_sel_mux #(.WIDTH(W), .N(N), .SELW(SW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  chan_sel_mux #(.WIDTH(W), .N(12), .SELW(5)) dut12 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data[12*W-1:0]),
    .in_valid  (in_valid[11:0]),
    .in_ready  (in_ready2),
    .mode      (1'b0),
    .sel       (sel2),
    .out_data  (out_data2),
    .out_chan  (out_chan2),
    .out_valid (out_valid2),
    .out_ready (1'b1)
  );

  function automatic logic [W-1:0] word(input int k, input logic [7:0] t);
    return {t, 8'hA5, 12'h000, 4'(k)};
  endfunction

  task automatic set_data(input logic [7:0] t);
    tag = t;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = word(k, t);
  endtask

  task automatic check(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (!reset_n || (m_valid && !out_ready)) return g;
    if (!mode) begin
      if (in_valid[sel]) g[sel] = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (int'(m_ptr) + i) % N;
        if (in_valid[c]) begin
          g[c] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    sbq.delete();
    m_valid = 1'b0;
    m_ptr   = '0;
  endtask

  // Checks the model against the DUT for one cycle, then advances past the edge.
  task automatic cycle();
    logic [N-1:0] g;
    item_t        e;
    int           k;
    #1;
    g = model_grant();
    check("in_ready", 64'(in_ready), 64'(g));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid && out_ready) begin
      check("sb_nonempty", 64'(sbq.size() > 0), 64'(1));
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_data", 64'(out_data), 64'(e.d));
        check("sb_chan", 64'(out_chan), 64'(e.c));
      end
      m_valid = 1'b0;
    end
    if (g != '0) begin
      k = 0;
      for (int j = 0; j < N; j++) if (g[j]) k = j;
      e.d = word(k, tag);
      e.c = SW'(k);
      sbq.push_back(e);
      m_valid = 1'b1;
      if (mode) m_ptr = SW'((k + 1) % N);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_exp(input logic [N-1:0] e);
    #1;
    check("in_ready_dir", 64'(in_ready), 64'(e));
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    sel2      = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_data(8'hA5);
    model_reset();

    // Reset with every channel requesting
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_chan", 64'(out_chan), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_in_ready12", 64'(in_ready2), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Round-robin over all channels, twice
    for (int i = 0; i < 32; i++) begin
      cyc_exp(N'(1 << (i % N)));
      check("rr_chan", 64'(out_chan), 64'(i % N));
    end

    // Two requesters alternate
    in_valid = 16'h0009;
    cyc_exp(16'h0001);
    cyc_exp(16'h0008);
    cyc_exp(16'h0001);
    cyc_exp(16'h0008);

    // Wrap and skip: ch13 moves the pointer to 14, then ch0, ch1
    in_valid = 16'h2000;
    cyc_exp(16'h2000);
    in_valid = 16'h0003;
    cyc_exp(16'h0001);
    cyc_exp(16'h0002);
    in_valid = 16'h0011;
    cyc_exp(16'h0010);

    // Explicit select
    mode     = 1'b0;
    sel      = 4'd5;
    in_valid = '1;
    cyc_exp(16'h0020);
    check("sel5_data", 64'(out_data), 64'(32'hA5A5_0005));
    check("sel5_chan", 64'(out_chan), 64'(5));
    in_valid = 16'hFFDF;
    cyc_exp(16'h0000);
    check("sel5_hold_data", 64'(out_data), 64'(32'hA5A5_0005));

    // Out-of-range select on the 12-channel instance
    in_valid = '1;
    sel2 = 5'd16;
    #1 check("n12_sel16", 64'(in_ready2), 64'(0));
    sel2 = 5'd11;
    #1 check("n12_sel11", 64'(in_ready2), 64'(12'h800));
    sel2 = 5'd12;
    #1 check("n12_sel12", 64'(in_ready2), 64'(0));

    // Backpressure
    set_data(8'h3C);
    sel = 4'd7;
    cyc_exp(16'h0080);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel = SW'(i + 1);
      cyc_exp(16'h0000);
      check("bp_data", 64'(out_data), 64'(32'h3CA5_0007));
      check("bp_chan", 64'(out_chan), 64'(7));
    end
    out_ready = 1'b1;
    sel = 4'd9;
    cyc_exp(16'h0200);
    check("bp_reload_valid", 64'(out_valid), 64'(1));
    check("bp_reload_data", 64'(out_data), 64'(32'h3CA5_0009));

    // Mode switch while the register is held
    mode     = 1'b1;
    in_valid = 16'h0040;
    cyc_exp(16'h0040);
    out_ready = 1'b0;
    mode = 1'b0;
    sel  = 4'd2;
    in_valid = '1;
    cyc_exp(16'h0000);
    check("msw_data0", 64'(out_data), 64'(32'h3CA5_0006));
    mode = 1'b1;
    cyc_exp(16'h0000);
    check("msw_data1", 64'(out_data), 64'(32'h3CA5_0006));
    check("msw_chan", 64'(out_chan), 64'(6));

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_data", 64'(out_data), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(0));
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    cyc_exp(16'h0001);
    check("post_rst_chan", 64'(out_chan), 64'(0));
    in_valid = '0;
    cyc_exp(16'h0000);
    check("final_empty", 64'(out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
